// File: rtl/cla_seq_adder.sv
// cla_seq_adder
// Multi-cycle WIDTH-bit adder/subtractor. It reuses one 4-bit carry-lookahead
// slice (cla4) over the operands, one nibble per cycle, least-significant
// nibble first. The carry between nibbles is held in a register.
//
// Ports:
//   clk       - sole clock, rising edge
//   rst       - synchronous, active-high reset
//   in_valid  - operands and mode present
//   in_ready  - block can accept an operation (IDLE only)
//   a, b      - WIDTH-bit operands
//   c_in      - carry-in for add (ignored when sub=1)
//   sub       - 1: compute a - b as a + ~b + 1
//   out_valid - s/c_out/ovf hold a completed operation (DONE only)
//   out_ready - consumer takes the result
//   s         - sum or difference
//   c_out     - carry out of bit WIDTH-1 (for sub, 1 means no borrow)
//   ovf       - two's-complement signed overflow

// 4-bit carry-lookahead slice: every carry is formed directly from the
// generate/propagate terms and c_in, with no ripple between bits.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = c_in;
    c[1] = g[0] | (p[0] & c_in);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
    s     = p ^ c[3:0];
    c_out = c[4];
  end
endmodule

module cla_seq_adder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);
  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // effective B: already inverted for sub
  logic             carry_q, carry_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_c;

  assign accept = in_valid && (state_q == IDLE);
  assign nib_a  = a_q[4*k_q +: 4];
  assign nib_b  = b_q[4*k_q +: 4];

  // The single shared slice; nibble k of the captured operands each RUN cycle.
  cla4 u_cla4 (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry_q),
    .s     (nib_s),
    .c_out (nib_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      k_q     <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
    // Operand holding registers carry no control meaning; they are always
    // reloaded on accept before being used.
    a_q <= a_d;
    b_q <= b_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (k_q == K_LAST) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    k_d     = k_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          k_d     = '0;
          s_d     = '0;
        end
      end
      RUN: begin
        s_d[4*k_q +: 4] = nib_s;
        carry_d         = nib_c;
        if (k_q == K_LAST) begin
          c_out_d = nib_c;
          // nib_s[3] is bit WIDTH-1 of the result in the last nibble.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_s[3] != a_q[WIDTH-1]);
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs: decoded from registered state only
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    s         = s_q;
    c_out     = c_out_q;
    ovf       = ovf_q;
  end
endmodule
